// File: rtl/tetris_pkg.sv
// tetris_pkg
// Shared types and board constants for the falling-piece control logic.
//   move_e     : which single-step move a button event requests
//   mv_state_e : move controller handshake state
//   BOARD_*    : playfield geometry feeding the default coordinate bounds
package tetris_pkg;

  localparam int BOARD_W     = 10;
  localparam int BOARD_H     = 20;
  localparam int BOARD_X_MIN = 0;
  localparam int BOARD_X_MAX = BOARD_W - 1;
  localparam int BOARD_Y_MAX = BOARD_H - 1;

  typedef enum logic [2:0] {
    MV_NONE,
    MV_LEFT,
    MV_RIGHT,
    MV_DOWN,
    MV_ROT
  } move_e;

  typedef enum logic {
    MV_IDLE,
    MV_REQ
  } mv_state_e;

endpackage

// File: rtl/piece_move_ctrl_if.sv
// piece_move_ctrl_if
// Candidate handshake between the move controller and the collision checker.
//   cand_x/cand_y/cand_rot : proposed piece state (controller -> checker)
//   cand_valid             : a candidate is pending (controller -> checker)
//   cand_ready             : checker takes the candidate this cycle (checker -> controller)
//   cand_ok                : checker verdict, meaningful only with cand_valid && cand_ready
// Modports: master = move controller, slave = collision checker.
interface piece_move_ctrl_if #(
  parameter int X_W   = 5,
  parameter int Y_W   = 5,
  parameter int ROT_N = 4
);
  localparam int ROT_W = $clog2(ROT_N);

  logic [X_W-1:0]   cand_x;
  logic [Y_W-1:0]   cand_y;
  logic [ROT_W-1:0] cand_rot;
  logic             cand_valid;
  logic             cand_ready;
  logic             cand_ok;

  modport master (
    output cand_x, cand_y, cand_rot, cand_valid,
    input  cand_ready, cand_ok
  );

  modport slave (
    input  cand_x, cand_y, cand_rot, cand_valid,
    output cand_ready, cand_ok
  );

endinterface

// File: rtl/piece_move_ctrl_btn_repeat.sv
// btn_repeat
// Turns one level button into registered one-cycle move events.
// Optional feature macro: AUTO_REPEAT_EN (adds hold-to-repeat).
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : level button, already synchronous to clk
//   clr        : abandon any hold; the button must be released before it fires again
//   evt        : one-cycle event, registered on the edge that saw the press/repeat
module btn_repeat #(
  parameter int DAS_DELAY = 16,
  parameter int DAS_RATE  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic clr,
  output logic evt
);

  if (DAS_DELAY < 2 || DAS_RATE < 1) begin : g_bad_cfg
    $error("btn_repeat: DAS_DELAY must be >= 2 and DAS_RATE >= 1");
  end

  logic btn_prev_q;
  logic evt_q;

`ifdef AUTO_REPEAT_EN
  localparam int CNT_MAX = (DAS_DELAY > DAS_RATE) ? DAS_DELAY : DAS_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Down-counter: loaded with DAS_DELAY-1 on the press edge, so it reaches 0
  // exactly DAS_DELAY edges after the press; each repeat reloads DAS_RATE-1.
  // armed_q stops a button still held across a clr from repeating.
  logic [CNT_W-1:0] cnt_q;
  logic             armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev_q <= 1'b0;
      evt_q      <= 1'b0;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
    end else if (clr) begin
      btn_prev_q <= btn;
      evt_q      <= 1'b0;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
    end else begin
      btn_prev_q <= btn;
      evt_q      <= 1'b0;
      if (!btn) begin
        cnt_q   <= '0;
        armed_q <= 1'b0;
      end else if (!btn_prev_q) begin
        evt_q   <= 1'b1;
        cnt_q   <= CNT_W'(DAS_DELAY - 1);
        armed_q <= 1'b1;
      end else if (armed_q) begin
        if (cnt_q == '0) begin
          evt_q <= 1'b1;
          cnt_q <= CNT_W'(DAS_RATE - 1);
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end
`else
  // Rising-edge detect only; clr copies the live level so a held button
  // produces no edge until it is released and pressed again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev_q <= 1'b0;
      evt_q      <= 1'b0;
    end else if (clr) begin
      btn_prev_q <= btn;
      evt_q      <= 1'b0;
    end else begin
      btn_prev_q <= btn;
      evt_q      <= btn & ~btn_prev_q;
    end
  end
`endif

  assign evt = evt_q;

endmodule

// File: rtl/piece_move_ctrl.sv
// piece_move_ctrl
// Move controller for the falling piece: button events become single-step
// move/rotate candidates, offered to the collision checker over a
// valid/ready handshake, and committed only when the checker approves.
// Optional feature macro: AUTO_REPEAT_EN (hold-to-repeat in btn_repeat).
//   clk, rst_n                : clock, asynchronous active-low reset
//   btn_left/right/down/rot   : synchronous level buttons
//   load, load_x/y/rot        : spawn pulse and the state it loads
//   pos_x, pos_y, rot         : committed piece state
//   move_rej                  : one-cycle pulse, candidate rejected
//   lock                      : one-cycle pulse, a down move was refused
//   cand_if (master)          : candidate handshake to the collision checker
module piece_move_ctrl
  import tetris_pkg::*;
#(
  parameter int X_W       = 5,
  parameter int Y_W       = 5,
  parameter int ROT_N     = 4,
  parameter int X_MIN     = BOARD_X_MIN,
  parameter int X_MAX     = BOARD_X_MAX,
  parameter int Y_MAX     = BOARD_Y_MAX,
  parameter int X_SPAWN   = 4,
  parameter int Y_SPAWN   = 0,
  parameter int DAS_DELAY = 16,
  parameter int DAS_RATE  = 4,
  localparam int ROT_W    = $clog2(ROT_N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_down,
  input  logic             btn_rot,
  input  logic             load,
  input  logic [X_W-1:0]   load_x,
  input  logic [Y_W-1:0]   load_y,
  input  logic [ROT_W-1:0] load_rot,
  output logic [X_W-1:0]   pos_x,
  output logic [Y_W-1:0]   pos_y,
  output logic [ROT_W-1:0] rot,
  output logic             move_rej,
  output logic             lock,
  piece_move_ctrl_if.master cand_if
);

  localparam logic [X_W-1:0]   X_MIN_V   = X_W'(X_MIN);
  localparam logic [X_W-1:0]   X_MAX_V   = X_W'(X_MAX);
  localparam logic [Y_W-1:0]   Y_MAX_V   = Y_W'(Y_MAX);
  localparam logic [ROT_W-1:0] ROT_LAST  = ROT_W'(ROT_N - 1);

  logic evt_left, evt_right, evt_down, evt_rot;

  btn_repeat #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE)) u_rep_left (
    .clk(clk), .rst_n(rst_n), .btn(btn_left),  .clr(load), .evt(evt_left)
  );
  btn_repeat #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE)) u_rep_right (
    .clk(clk), .rst_n(rst_n), .btn(btn_right), .clr(load), .evt(evt_right)
  );
  btn_repeat #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE)) u_rep_down (
    .clk(clk), .rst_n(rst_n), .btn(btn_down),  .clr(load), .evt(evt_down)
  );
  btn_repeat #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE)) u_rep_rot (
    .clk(clk), .rst_n(rst_n), .btn(btn_rot),   .clr(load), .evt(evt_rot)
  );

  mv_state_e        state_q, state_d;
  move_e            mv_q, mv_d, mv_evt;
  logic [X_W-1:0]   pos_x_q, pos_x_d, cand_x_q, cand_x_d;
  logic [Y_W-1:0]   pos_y_q, pos_y_d, cand_y_q, cand_y_d;
  logic [ROT_W-1:0] rot_q, rot_d, cand_rot_q, cand_rot_d;
  logic             move_rej_q, move_rej_d, lock_q, lock_d;

  // Fixed priority left > right > down > rot; losers are simply dropped.
  always_comb begin
    mv_evt = MV_NONE;
    if (evt_left)       mv_evt = MV_LEFT;
    else if (evt_right) mv_evt = MV_RIGHT;
    else if (evt_down)  mv_evt = MV_DOWN;
    else if (evt_rot)   mv_evt = MV_ROT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MV_IDLE;
      mv_q       <= MV_NONE;
      pos_x_q    <= X_W'(X_SPAWN);
      pos_y_q    <= Y_W'(Y_SPAWN);
      rot_q      <= '0;
      cand_x_q   <= '0;
      cand_y_q   <= '0;
      cand_rot_q <= '0;
      move_rej_q <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mv_q       <= mv_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      rot_q      <= rot_d;
      cand_x_q   <= cand_x_d;
      cand_y_q   <= cand_y_d;
      cand_rot_q <= cand_rot_d;
      move_rej_q <= move_rej_d;
      lock_q     <= lock_d;
    end
  end

  // Bounds are checked on the committed position before the +/-1, so the
  // candidate arithmetic can never wrap. load overrides everything and
  // silently abandons a pending candidate.
  always_comb begin
    state_d    = state_q;
    mv_d       = mv_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    rot_d      = rot_q;
    cand_x_d   = cand_x_q;
    cand_y_d   = cand_y_q;
    cand_rot_d = cand_rot_q;
    move_rej_d = 1'b0;
    lock_d     = 1'b0;

    if (load) begin
      pos_x_d = load_x;
      pos_y_d = load_y;
      rot_d   = load_rot;
      state_d = MV_IDLE;
    end else begin
      unique case (state_q)
        MV_IDLE: begin
          case (mv_evt)
            MV_LEFT: begin
              if (pos_x_q > X_MIN_V) begin
                cand_x_d   = pos_x_q - X_W'(1);
                cand_y_d   = pos_y_q;
                cand_rot_d = rot_q;
                mv_d       = MV_LEFT;
                state_d    = MV_REQ;
              end
            end
            MV_RIGHT: begin
              if (pos_x_q < X_MAX_V) begin
                cand_x_d   = pos_x_q + X_W'(1);
                cand_y_d   = pos_y_q;
                cand_rot_d = rot_q;
                mv_d       = MV_RIGHT;
                state_d    = MV_REQ;
              end
            end
            MV_DOWN: begin
              if (pos_y_q < Y_MAX_V) begin
                cand_x_d   = pos_x_q;
                cand_y_d   = pos_y_q + Y_W'(1);
                cand_rot_d = rot_q;
                mv_d       = MV_DOWN;
                state_d    = MV_REQ;
              end else begin
                // Already on the floor: the piece lands without asking the checker.
                lock_d = 1'b1;
              end
            end
            MV_ROT: begin
              cand_x_d   = pos_x_q;
              cand_y_d   = pos_y_q;
              cand_rot_d = (rot_q == ROT_LAST) ? '0 : rot_q + ROT_W'(1);
              mv_d       = MV_ROT;
              state_d    = MV_REQ;
            end
            default: ;
          endcase
        end
        MV_REQ: begin
          if (cand_if.cand_ready) begin
            if (cand_if.cand_ok) begin
              pos_x_d = cand_x_q;
              pos_y_d = cand_y_q;
              rot_d   = cand_rot_q;
            end else begin
              move_rej_d = 1'b1;
              lock_d     = (mv_q == MV_DOWN);
            end
            state_d = MV_IDLE;
          end
        end
        default: state_d = MV_IDLE;
      endcase
    end
  end

  assign pos_x               = pos_x_q;
  assign pos_y               = pos_y_q;
  assign rot                 = rot_q;
  assign move_rej            = move_rej_q;
  assign lock                = lock_q;
  assign cand_if.cand_x      = cand_x_q;
  assign cand_if.cand_y      = cand_y_q;
  assign cand_if.cand_rot    = cand_rot_q;
  assign cand_if.cand_valid  = (state_q == MV_REQ);

endmodule
